prm_oblgc_query: RTL

Sequencer that drives obstacle occupancy codes into the bank of combinational PRM edge checkers (`prm_oblgc_chk*`) and collects their `edge_mask` outputs. It accepts a batch of 15-bit codes over a valid/ready stream and broadcasts each code to every checker as inputs A..O. It ORs the returned per-edge masks into a blocked-edge bitmap and hands the bitmap to the roadmap planner once the batch completes.

---
 rtl/prm_oblgc_pkg.sv | 57 +++++
 rtl/prm_oblgc_acc.sv | 39 +++
 rtl/prm_oblgc_query.sv | 137 +++++++++++++
 3 files changed

// File: rtl/prm_oblgc_pkg.sv
// Shared types and constants for the PRM obstacle-code query sequencer.
// Build option: PRM_OBLGC_EARLY_EXIT_EN adds the DRAIN state.
package prm_oblgc_pkg;

   localparam int CODE_W = 15;

   // Checker input letters and the code bit that drives each one.
   localparam int CHK_A = 0;
   localparam int CHK_B = 1;
   localparam int CHK_C = 2;
   localparam int CHK_D = 3;
   localparam int CHK_E = 4;
   localparam int CHK_F = 5;
   localparam int CHK_G = 6;
   localparam int CHK_H = 7;
   localparam int CHK_I = 8;
   localparam int CHK_J = 9;
   localparam int CHK_K = 10;
   localparam int CHK_L = 11;
   localparam int CHK_M = 12;
   localparam int CHK_N = 13;
   localparam int CHK_O = 14;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_DONE   = 3'd3
`ifdef PRM_OBLGC_EARLY_EXIT_EN
      ,
      ST_DRAIN  = 3'd4
`endif
   } state_e;

   // Places each occupancy bit on the checker input it is wired to.
   function automatic logic [CODE_W-1:0] to_checker(input logic [CODE_W-1:0] code);
      logic [CODE_W-1:0] r;
      r        = '0;
      r[CHK_A] = code[0];
      r[CHK_B] = code[1];
      r[CHK_C] = code[2];
      r[CHK_D] = code[3];
      r[CHK_E] = code[4];
      r[CHK_F] = code[5];
      r[CHK_G] = code[6];
      r[CHK_H] = code[7];
      r[CHK_I] = code[8];
      r[CHK_J] = code[9];
      r[CHK_K] = code[10];
      r[CHK_L] = code[11];
      r[CHK_M] = code[12];
      r[CHK_N] = code[13];
      r[CHK_O] = code[14];
      return r;
   endfunction

endpackage

// File: rtl/prm_oblgc_acc.sv
// OR accumulator for the blocked-edge bitmap, with clear, enable and
// all-ones detect (all-ones port exists only with PRM_OBLGC_EARLY_EXIT_EN).
module prm_oblgc_acc #(
   parameter int NUM_EDGE = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                en,
   input  logic [NUM_EDGE-1:0] mask,
   output logic [NUM_EDGE-1:0] acc
`ifdef PRM_OBLGC_EARLY_EXIT_EN
   ,
   output logic                all_ones
`endif
);

   logic [NUM_EDGE-1:0] acc_or;

   assign acc_or = acc | mask;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_or;
      end
   end

`ifdef PRM_OBLGC_EARLY_EXIT_EN
   // Looks at the value about to be stored, so saturation is seen in SAMPLE.
   assign all_ones = &acc_or;
`endif

endmodule

// File: rtl/prm_oblgc_query.sv
// Sequencer broadcasting occupancy codes to the PRM edge checkers and ORing
// their edge masks into a blocked-edge bitmap. Option: PRM_OBLGC_EARLY_EXIT_EN.
module prm_oblgc_query
   import prm_oblgc_pkg::*;
#(
   parameter int NUM_EDGE = 64,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [CNT_W-1:0]    code_cnt,
   output logic                busy,
   input  logic                code_valid,
   input  logic [CODE_W-1:0]   code_data,
   output logic                code_ready,
   output logic [CODE_W-1:0]   chk_code,
   input  logic [NUM_EDGE-1:0] chk_mask,
   output logic [NUM_EDGE-1:0] blocked,
   output logic                blocked_valid,
   input  logic                blocked_ready
);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] remaining;
   logic             load, dec, capture, acc_clr, acc_en;
   logic             last_code;

   assign last_code = (remaining == CNT_W'(1));
   assign busy      = (state != ST_IDLE);

`ifdef PRM_OBLGC_EARLY_EXIT_EN
   logic all_ones;
`endif

   prm_oblgc_acc #(
      .NUM_EDGE (NUM_EDGE)
   ) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (acc_clr),
      .en       (acc_en),
      .mask     (chk_mask),
      .acc      (blocked)
`ifdef PRM_OBLGC_EARLY_EXIT_EN
      ,
      .all_ones (all_ones)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         remaining <= '0;
         chk_code  <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            remaining <= code_cnt;
         end else if (dec) begin
            remaining <= remaining - CNT_W'(1);
         end
         if (capture) begin
            chk_code <= to_checker(code_data);
         end
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt     = state;
      code_ready    = 1'b0;
      blocked_valid = 1'b0;
      load          = 1'b0;
      dec           = 1'b0;
      capture       = 1'b0;
      acc_clr       = 1'b0;
      acc_en        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               acc_clr = 1'b1;
               if (code_cnt != '0) begin
                  load      = 1'b1;
                  state_nxt = ST_FETCH;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_FETCH: begin
            code_ready = 1'b1;
            if (code_valid) begin
               capture   = 1'b1;
               state_nxt = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            // chk_code has been stable for a full cycle, so chk_mask has settled.
            acc_en = 1'b1;
            dec    = 1'b1;
            if (last_code) begin
               state_nxt = ST_DONE;
`ifdef PRM_OBLGC_EARLY_EXIT_EN
            end else if (all_ones) begin
               state_nxt = ST_DRAIN;
`endif
            end else begin
               state_nxt = ST_FETCH;
            end
         end
`ifdef PRM_OBLGC_EARLY_EXIT_EN
         ST_DRAIN: begin
            // Result is already saturated; remaining codes are consumed unseen.
            code_ready = 1'b1;
            if (code_valid) begin
               dec = 1'b1;
               if (last_code) begin
                  state_nxt = ST_DONE;
               end
            end
         end
`endif
         ST_DONE: begin
            blocked_valid = 1'b1;
            if (blocked_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
